pkt_disassembler: RTL and testbench



---
 rtl/pkt_disassembler.sv | 121 ++++++++++++
 tb/tb_pkt_disassembler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_disassembler.sv
// Receive-side SpiNNaker packet disassembler: round-robin arbitrates rx packet
// channels, drops parity-failed packets and emits key/payload as 32-bit events.
module pkt_disassembler #(
    parameter int PACKET_BITS  = 72,
    parameter int NUM_CHANNELS = 8,
    parameter int CHAN_BITS    = $clog2(NUM_CHANNELS),
    parameter int CNT_BITS     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] rxpkt_data_in [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] rxpkt_vld_in,
    output logic [NUM_CHANNELS-1:0] rxpkt_rdy_out,
    output logic [31:0]            evt_data_out,
    output logic [CHAN_BITS-1:0]   evt_chan_out,
    output logic                   evt_last_out,
    output logic                   evt_vld_out,
    input  logic                   evt_rdy_in,
    output logic [CNT_BITS-1:0]    drop_cnt_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        PLD  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CHAN_BITS-1:0] ptr;
    logic [CHAN_BITS-1:0] grant;
    logic [CHAN_BITS-1:0] cand;
    logic                 found;
    int unsigned          idx;
    logic [PACKET_BITS-1:0] pkt;
    logic                 parity_ok;
    logic                 accept;

    logic [31:0]          key_q;
    logic [31:0]          pld_q;
    logic                 has_pld_q;
    logic [CHAN_BITS-1:0] chan_q;
    logic [CNT_BITS-1:0]  drop_cnt_q;

    // Rotating-priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            idx  = (32'(ptr) + i) % NUM_CHANNELS;
            cand = CHAN_BITS'(idx);
            if (!found && rxpkt_vld_in[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign pkt       = rxpkt_data_in[grant];
    assign parity_ok = pkt[1] ? (^pkt) : (^pkt[39:0]);

    always_comb begin
        state_nxt     = state;
        rxpkt_rdy_out = '0;
        accept        = 1'b0;
        evt_vld_out   = 1'b0;
        evt_last_out  = 1'b0;
        evt_data_out  = key_q;
        evt_chan_out  = chan_q;
        unique case (state)
            IDLE: begin
                if (found && !reset) begin
                    rxpkt_rdy_out[grant] = 1'b1;
                    accept               = 1'b1;
                    if (parity_ok) state_nxt = KEY;
                end
            end
            KEY: begin
                evt_vld_out  = 1'b1;
                evt_last_out = !has_pld_q;
                if (evt_rdy_in) state_nxt = has_pld_q ? PLD : IDLE;
            end
            PLD: begin
                evt_vld_out  = 1'b1;
                evt_last_out = 1'b1;
                evt_data_out = pld_q;
                if (evt_rdy_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            key_q      <= '0;
            pld_q      <= '0;
            has_pld_q  <= 1'b0;
            chan_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr <= (grant == CHAN_BITS'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
                if (parity_ok) begin
                    key_q     <= pkt[39:8];
                    pld_q     <= pkt[71:40];
                    has_pld_q <= pkt[1];
                    chan_q    <= grant;
                end else if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

    assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_pkt_disassembler.sv
// Directed self-checking bench for pkt_disassembler.
module tb_pkt_disassembler;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] rx_data [8];
    logic [7:0]  rx_vld;
    logic [7:0]  rx_rdy;
    logic [31:0] evt_data;
    logic [2:0]  evt_chan;
    logic        evt_last;
    logic        evt_vld;
    logic        evt_rdy;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    pkt_disassembler #(
        .PACKET_BITS (72),
        .NUM_CHANNELS(8),
        .CNT_BITS    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxpkt_data_in(rx_data),
        .rxpkt_vld_in (rx_vld),
        .rxpkt_rdy_out(rx_rdy),
        .evt_data_out (evt_data),
        .evt_chan_out (evt_chan),
        .evt_last_out (evt_last),
        .evt_vld_out  (evt_vld),
        .evt_rdy_in   (evt_rdy),
        .drop_cnt_out (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        rx_vld  = '0;
        evt_rdy = 1'b0;
        for (int i = 0; i < 8; i++) rx_data[i] = '0;
        tick;
        tick;
        reset = 1'b0;
        checks++;
        if (evt_vld !== 1'b0 || evt_last !== 1'b0 || evt_data !== 32'h0 || evt_chan !== 3'd0) begin
            errors++;
            $display("FAIL reset_evt: vld=%b last=%b data=%h chan=%0d, want 0 0 0 0",
                     evt_vld, evt_last, evt_data, evt_chan);
        end
        checks++;
        if (rx_rdy !== 8'h00 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_rdy_cnt: rdy=%b drop=%h, want 00000000 0000", rx_rdy, drop_cnt);
        end
    endtask

    task automatic test_single;
        rx_data[3] = {32'h0, 32'h0000_0001, 8'h00};
        rx_vld     = 8'b0000_1000;
        evt_rdy    = 1'b1;
        #1;
        checks++;
        if (rx_rdy !== 8'b0000_1000) begin
            errors++;
            $display("FAIL single_rdy: rdy=%b want 00001000", rx_rdy);
        end
        tick;
        rx_vld = '0;
        checks++;
        if (evt_vld !== 1'b1 || evt_data !== 32'h1 || evt_chan !== 3'd3 || evt_last !== 1'b1) begin
            errors++;
            $display("FAIL single_key: vld=%b data=%h chan=%0d last=%b, want 1 00000001 3 1",
                     evt_vld, evt_data, evt_chan, evt_last);
        end
        tick;
        checks++;
        if (evt_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_done: vld=%b want 0", evt_vld);
        end
        // ptr should now be 4: with ch2 and ch5 pending, ch5 wins
        rx_data[2] = {32'h0, 32'h0000_0001, 8'h00};
        rx_data[5] = {32'h0, 32'h0000_0001, 8'h00};
        rx_vld     = 8'b0010_0100;
        #1;
        checks++;
        if (rx_rdy !== 8'b0010_0000) begin
            errors++;
            $display("FAIL single_ptr: rdy=%b want 00100000", rx_rdy);
        end
        rx_vld = '0;
    endtask

    task automatic test_backpressure;
        rx_data[0] = {32'h0000_0003, 32'h0000_0001, 8'h03};
        rx_vld     = 8'b0000_0001;
        evt_rdy    = 1'b0;
        #1;
        checks++;
        if (rx_rdy !== 8'b0000_0001) begin
            errors++;
            $display("FAIL bp_rdy: rdy=%b want 00000001", rx_rdy);
        end
        tick;
        rx_vld = '0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (evt_vld !== 1'b1 || evt_data !== 32'h1 || evt_last !== 1'b0 ||
                evt_chan !== 3'd0 || rx_rdy !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold_key[%0d]: vld=%b data=%h last=%b chan=%0d rdy=%b, want 1 00000001 0 0 00000000",
                         c, evt_vld, evt_data, evt_last, evt_chan, rx_rdy);
            end
            tick;
        end
        evt_rdy = 1'b1;
        #1;
        checks++;
        if (evt_vld !== 1'b1 || evt_data !== 32'h1 || evt_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_key_release: vld=%b data=%h last=%b, want 1 00000001 0",
                     evt_vld, evt_data, evt_last);
        end
        tick;
        checks++;
        if (evt_vld !== 1'b1 || evt_data !== 32'h3 || evt_last !== 1'b1 || evt_chan !== 3'd0) begin
            errors++;
            $display("FAIL bp_pld: vld=%b data=%h last=%b chan=%0d, want 1 00000003 1 0",
                     evt_vld, evt_data, evt_last, evt_chan);
        end
        tick;
        checks++;
        if (evt_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: vld=%b want 0", evt_vld);
        end
    endtask

    task automatic test_fairness;
        logic [2:0] order [6];
        order = '{3'd1, 3'd2, 3'd7, 3'd1, 3'd2, 3'd7};
        rx_data[1] = {32'h0, 32'h0000_0002, 8'h00};
        rx_data[2] = {32'h0, 32'h0000_0004, 8'h00};
        rx_data[7] = {32'h0, 32'h0000_0080, 8'h00};
        rx_vld     = 8'b1000_0110;
        evt_rdy    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (rx_rdy !== (8'h01 << order[k])) begin
                errors++;
                $display("FAIL fair_grant[%0d]: rdy=%b want ch%0d", k, rx_rdy, order[k]);
            end
            tick;
            checks++;
            if (evt_vld !== 1'b1 || evt_chan !== order[k] ||
                evt_data !== (32'h1 << order[k]) || evt_last !== 1'b1) begin
                errors++;
                $display("FAIL fair_evt[%0d]: vld=%b chan=%0d data=%h last=%b, want 1 %0d %h 1",
                         k, evt_vld, evt_chan, evt_data, evt_last, order[k], 32'h1 << order[k]);
            end
            tick;
        end
        rx_vld = '0;
    endtask

    task automatic test_parity_drop;
        rx_data[5] = {32'h0, 32'h0000_0001, 8'h01};
        rx_vld     = 8'b0010_0000;
        #1;
        checks++;
        if (rx_rdy !== 8'b0010_0000 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL drop_rdy: rdy=%b drop=%h, want 00100000 0000", rx_rdy, drop_cnt);
        end
        tick;
        rx_vld = '0;
        #1;
        checks++;
        if (evt_vld !== 1'b0 || drop_cnt !== 16'h1 || rx_rdy !== 8'h00) begin
            errors++;
            $display("FAIL drop_after: vld=%b drop=%h rdy=%b, want 0 0001 00000000",
                     evt_vld, drop_cnt, rx_rdy);
        end
        // still IDLE: a new valid is granted at once (search from 6 wraps to 1)
        rx_data[1] = {32'h0, 32'h0000_0002, 8'h00};
        rx_vld     = 8'b0000_0010;
        #1;
        checks++;
        if (rx_rdy !== 8'b0000_0010) begin
            errors++;
            $display("FAIL drop_idle: rdy=%b want 00000010", rx_rdy);
        end
        rx_vld = '0;
    endtask

    task automatic test_saturation;
        rx_vld = 8'b0010_0000;
        repeat (65533) tick;
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_fffe: drop=%h want fffe", drop_cnt);
        end
        tick;
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_ffff: drop=%h want ffff", drop_cnt);
        end
        tick;
        tick;
        rx_vld = '0;
        checks++;
        if (drop_cnt !== 16'hFFFF || evt_vld !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: drop=%h vld=%b want ffff 0", drop_cnt, evt_vld);
        end
    endtask

    task automatic test_reset_mid;
        rx_data[4] = {32'h0000_0003, 32'h0000_0001, 8'h03};
        rx_vld     = 8'b0001_0000;
        evt_rdy    = 1'b1;
        tick;
        rx_vld = '0;
        tick;
        evt_rdy = 1'b0;
        checks++;
        if (evt_vld !== 1'b1 || evt_data !== 32'h3 || evt_chan !== 3'd4) begin
            errors++;
            $display("FAIL mid_pld: vld=%b data=%h chan=%0d want 1 00000003 4", evt_vld, evt_data, evt_chan);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (evt_vld !== 1'b0 || rx_rdy !== 8'h00 || drop_cnt !== 16'h0 ||
            evt_data !== 32'h0 || evt_last !== 1'b0 || evt_chan !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: vld=%b rdy=%b drop=%h data=%h last=%b chan=%0d, want all 0",
                     evt_vld, rx_rdy, drop_cnt, evt_data, evt_last, evt_chan);
        end
        // ptr back at 0: ch2 beats ch6
        rx_data[2] = {32'h0, 32'h0000_0004, 8'h00};
        rx_data[6] = {32'h0, 32'h0000_0040, 8'h00};
        rx_vld     = 8'b0100_0100;
        #1;
        checks++;
        if (rx_rdy !== 8'b0000_0100) begin
            errors++;
            $display("FAIL mid_ptr: rdy=%b want 00000100", rx_rdy);
        end
        rx_vld  = 8'b0100_0000;
        evt_rdy = 1'b1;
        #1;
        checks++;
        if (rx_rdy !== 8'b0100_0000) begin
            errors++;
            $display("FAIL mid_ch6_rdy: rdy=%b want 01000000", rx_rdy);
        end
        tick;
        rx_vld = '0;
        checks++;
        if (evt_vld !== 1'b1 || evt_data !== 32'h40 || evt_chan !== 3'd6 || evt_last !== 1'b1) begin
            errors++;
            $display("FAIL mid_ch6_evt: vld=%b data=%h chan=%0d last=%b, want 1 00000040 6 1",
                     evt_vld, evt_data, evt_chan, evt_last);
        end
        tick;
        checks++;
        if (evt_vld !== 1'b0) begin
            errors++;
            $display("FAIL mid_ch6_done: vld=%b want 0", evt_vld);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_fairness;
        test_parity_drop;
        test_saturation;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
